// File: rtl/fifo_guarded_if.sv
// Producer/consumer bundle for fifo_guarded: write/read requests, data and status.
// master = the datapath using the FIFO, slave = the FIFO itself.
interface fifo_guarded_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  logic                   we;
  logic                   re;
  logic [WIDTH-1:0]       dataIn;
  logic [WIDTH-1:0]       dataOut;
  logic                   dout_valid;
  logic                   full_flag;
  logic                   almost_full;
  logic                   empty_flag;
  logic                   almost_empty;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   underflow;
  logic                   peak_clr;
  logic [$clog2(DEPTH):0] peak_level;

  modport master (
    output we, re, dataIn, peak_clr,
    input  dataOut, dout_valid, full_flag, almost_full, empty_flag, almost_empty,
    input  level, overflow, underflow, peak_level
  );

  modport slave (
    input  we, re, dataIn, peak_clr,
    output dataOut, dout_valid, full_flag, almost_full, empty_flag, almost_empty,
    output level, overflow, underflow, peak_level
  );
endinterface

// File: rtl/fifo_guarded.sv
// Guarded single-clock FIFO: exact level/flags, overflow/underflow pulses, FWFT or registered read.
// Optional peak-occupancy tracker built only when FIFO_PEAK_LEVEL_EN is defined.
module fifo_guarded #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int A_EMPTY = 2,
  parameter int A_FULL  = 2,
  parameter int FWFT    = 1
) (
  input logic           clk,
  input logic           rst,
  fifo_guarded_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] L_DEPTH  = LW'(DEPTH);
  localparam logic [LW-1:0] L_AFULL  = LW'(DEPTH - A_FULL);
  localparam logic [LW-1:0] L_AEMPTY = LW'(A_EMPTY);

  if (A_EMPTY >= DEPTH || A_FULL >= DEPTH) begin : g_thresh_check
    $error("fifo_guarded: A_EMPTY and A_FULL must both be below DEPTH");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fifo_guarded: DEPTH must be a power of two and at least 4");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic [LW-1:0]    w_level_nxt;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == L_DEPTH);
  // A read frees the slot in the same cycle, so a full FIFO still takes a paired write.
  assign w_rd_ok = bus.re && !w_empty;
  assign w_wr_ok = bus.we && (!w_full || w_rd_ok);

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_ok && !w_rd_ok) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_rd_ok && !w_wr_ok) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + LW'(1);
      r_level     <= w_level_nxt;
      r_overflow  <= bus.we && !w_wr_ok;
      r_underflow <= bus.re && !w_rd_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_wr_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.dataIn;
    end
  end

  assign bus.level        = r_level;
  assign bus.empty_flag   = w_empty;
  assign bus.full_flag    = w_full;
  assign bus.almost_empty = (r_level <= L_AEMPTY);
  assign bus.almost_full  = (r_level >= L_AFULL);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  if (FWFT != 0) begin : g_fwft
    assign bus.dataOut    = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.dout_valid = !w_empty;
  end else begin : g_regout
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_vld;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_dout     <= '0;
        r_dout_vld <= 1'b0;
      end else begin
        r_dout_vld <= w_rd_ok;
        if (w_rd_ok) r_dout <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end

    assign bus.dataOut    = r_dout;
    assign bus.dout_valid = r_dout_vld;
  end

`ifdef FIFO_PEAK_LEVEL_EN
  logic [LW-1:0] r_peak;

  // Clear reloads with the incoming level so a fill in the clear cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_peak <= '0;
    end else if (bus.peak_clr) begin
      r_peak <= w_level_nxt;
    end else if (w_level_nxt > r_peak) begin
      r_peak <= w_level_nxt;
    end
  end

  assign bus.peak_level = r_peak;
`else
  logic w_unused_peak_clr;
  assign w_unused_peak_clr = bus.peak_clr;
  assign bus.peak_level    = '0;
`endif
endmodule

// File: tb/tb_fifo_guarded.sv
// Scoreboard bench for fifo_guarded: FWFT and registered-read instances on a shared clock/reset.
module tb_fifo_guarded;
  localparam int W = 16;
  localparam int D = 16;
`ifdef FIFO_PEAK_LEVEL_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_guarded_if #(.WIDTH(W), .DEPTH(D)) if1 ();
  fifo_guarded_if #(.WIDTH(W), .DEPTH(D)) if0 ();

  fifo_guarded #(.WIDTH(W), .DEPTH(D), .A_EMPTY(2), .A_FULL(2), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  fifo_guarded #(.WIDTH(W), .DEPTH(D), .A_EMPTY(2), .A_FULL(2), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int         m_lvl;
  int         m_peak;
  logic       m_ov;
  logic       m_uf;
  logic [W-1:0] sb[$];

  int         m0_lvl;
  logic [W-1:0] m0_held;
  logic [W-1:0] sb0[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".level"},  32'(if1.level),        32'(m_lvl));
    chk({tag, ".full"},   32'(if1.full_flag),    32'(m_lvl == D));
    chk({tag, ".afull"},  32'(if1.almost_full),  32'(m_lvl >= D - 2));
    chk({tag, ".empty"},  32'(if1.empty_flag),   32'(m_lvl == 0));
    chk({tag, ".aempty"}, 32'(if1.almost_empty), 32'(m_lvl <= 2));
    chk({tag, ".vld"},    32'(if1.dout_valid),   32'(m_lvl != 0));
    chk({tag, ".ovf"},    32'(if1.overflow),     32'(m_ov));
    chk({tag, ".udf"},    32'(if1.underflow),    32'(m_uf));
    chk({tag, ".peak"},   32'(if1.peak_level),   32'(m_peak));
  endtask

  task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                      input logic clr, input string tag);
    logic rd_ok, wr_ok;
    logic [W-1:0] e;
    int nxt;
    @(negedge clk);
    if1.we = w; if1.re = r; if1.dataIn = d; if1.peak_clr = clr;
    rd_ok = r && (m_lvl != 0);
    wr_ok = w && ((m_lvl != D) || rd_ok);
    #1;
    if (rd_ok) begin
      e = sb.pop_front();
      chk({tag, ".dout"}, 32'(if1.dataOut), 32'(e));
    end
    if (wr_ok) sb.push_back(d);
    nxt  = m_lvl + int'(wr_ok) - int'(rd_ok);
    m_ov = w && !wr_ok;
    m_uf = r && !rd_ok;
    if (PEAK_ON) m_peak = clr ? nxt : ((nxt > m_peak) ? nxt : m_peak);
    else         m_peak = 0;
    @(posedge clk); #1;
    m_lvl = nxt;
    chk_state(tag);
  endtask

  task automatic step0(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    logic rd_ok, wr_ok;
    logic [W-1:0] e;
    @(negedge clk);
    if0.we = w; if0.re = r; if0.dataIn = d; if0.peak_clr = 1'b0;
    rd_ok = r && (m0_lvl != 0);
    wr_ok = w && ((m0_lvl != D) || rd_ok);
    e = rd_ok ? sb0.pop_front() : m0_held;
    if (wr_ok) sb0.push_back(d);
    m0_lvl = m0_lvl + int'(wr_ok) - int'(rd_ok);
    @(posedge clk); #1;
    chk({tag, ".vld"},   32'(if0.dout_valid), 32'(rd_ok));
    chk({tag, ".dout"},  32'(if0.dataOut),    32'(e));
    chk({tag, ".level"}, 32'(if0.level),      32'(m0_lvl));
    m0_held = e;
  endtask

  task automatic idle_inputs();
    if1.we = 1'b0; if1.re = 1'b0; if1.dataIn = '0; if1.peak_clr = 1'b0;
    if0.we = 1'b0; if0.re = 1'b0; if0.dataIn = '0; if0.peak_clr = 1'b0;
  endtask

  // Requests held high through the reset edge must be ignored and raise no error pulse.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    if1.we = 1'b1; if1.re = 1'b1; if1.dataIn = 16'hDEAD; if1.peak_clr = 1'b0;
    if0.we = 1'b1; if0.re = 1'b1; if0.dataIn = 16'hBEEF; if0.peak_clr = 1'b0;
    @(posedge clk); #1;
    m_lvl = 0; m_ov = 1'b0; m_uf = 1'b0; m_peak = 0; sb.delete();
    m0_lvl = 0; m0_held = '0; sb0.delete();
    chk_state(tag);
    chk({tag, ".r0.vld"},  32'(if0.dout_valid), 32'd0);
    chk({tag, ".r0.dout"}, 32'(if0.dataOut),    32'd0);
    chk({tag, ".r0.ovf"},  32'(if0.overflow),   32'd0);
    chk({tag, ".r0.udf"},  32'(if0.underflow),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    do_reset("reset");

    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 16'(i), 1'b0, "fill");
    step(1'b1, 1'b0, 16'h0BAD, 1'b0, "overfill");
    step(1'b0, 1'b0, 16'h0000, 1'b0, "ovf_clear");

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0000, 1'b0, "drain");
    step(1'b0, 1'b1, 16'h0000, 1'b0, "underread");
    step(1'b0, 1'b0, 16'h0000, 1'b0, "udf_clear");

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0, "refill");
    for (int i = 0; i < 5; i++)  step(1'b1, 1'b1, 16'h0300 + 16'(i), 1'b0, "full_rw");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0000, 1'b0, "wrap_drain");

    step(1'b1, 1'b1, 16'hABCD, 1'b0, "empty_rw");
    step(1'b0, 1'b1, 16'h0000, 1'b0, "empty_rw_rd");

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
           16'($urandom), 1'($urandom_range(0, 15) == 0), "rand");
    end

    do_reset("reset_pk");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b0, "pk_fill");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h0000, 1'b0, "pk_drain");
    chk("peak_max", 32'(if1.peak_level), PEAK_ON ? 32'd9 : 32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, "pk_clr");
    chk("peak_clr", 32'(if1.peak_level), PEAK_ON ? 32'd3 : 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0400 + 16'(i), 1'b0, "pk_refill");
    do_reset("reset_mid");
    chk("mid_rst_level", 32'(if1.level),      32'd0);
    chk("mid_rst_empty", 32'(if1.empty_flag), 32'd1);
    chk("mid_rst_peak",  32'(if1.peak_level), 32'd0);

    step0(1'b0, 1'b1, 16'h0000, "r0_underread");
    step0(1'b1, 1'b0, 16'h1234, "r0_wr");
    step0(1'b0, 1'b1, 16'h0000, "r0_rd");
    step0(1'b0, 1'b0, 16'h0000, "r0_hold");
    step0(1'b0, 1'b0, 16'h0000, "r0_hold2");
    for (int i = 0; i < 4; i++) step0(1'b1, 1'b0, 16'h0500 + 16'(i), "r0_fill");
    for (int i = 0; i < 5; i++) step0(1'b0, 1'b1, 16'h0000, "r0_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
